// File: rtl/riviera_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riviera_pkg
//  Description : Shared fetch-stream types and constants used by the IF, ID
//                and fetch-queue stages.
//  Revision    : 1.0  initial release
// ============================================================================
package riviera_pkg;

    // One fetched instruction together with the pc it was fetched from.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;

    // Canonical RISC-V NOP (addi x0, x0, 0), presented when nothing is valid.
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/id_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : id_fetch_queue
//  Description : Decode-side receiver for the fetch stream. Buffers {pc,instr}
//                packets from IF in a small first-word-fall-through queue,
//                applies backpressure to IF, and discards everything held or
//                arriving on an EX redirect while counting the discarded
//                packets in a saturating counter.
//  Revision    : 1.0  initial release
// ============================================================================
module id_fetch_queue
    import riviera_pkg::*;
#(
    parameter int   DEPTH  = 4,
    parameter int   DROP_W = 16,
    localparam int  CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_valid,
    input  logic [31:0]       i_if_instr,
    input  logic [63:0]       i_if_pc,
    output logic              o_if_ready,
    input  logic              i_ex_flush,
    output logic              o_id_valid,
    output logic [31:0]       o_id_instr,
    output logic [63:0]       o_id_pc,
    input  logic              i_dec_ready,
    output logic [CNT_W-1:0]  o_occupancy,
    output logic [DROP_W-1:0] o_flush_drops
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DROP_W-1:0] r_flush_drops;
    fetch_pkt_t        r_mem [DEPTH];

    logic              w_if_ready;
    logic              w_id_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_arrive;
    logic [DROP_W:0]   w_drop_sum;
    fetch_pkt_t        w_head;

    // Handshake qualifiers: ready/valid come from registered state only, so
    // there is no combinational path from any input to o_if_ready.
    assign w_if_ready = (r_count != CNT_W'(DEPTH));
    assign w_id_valid = (r_count != '0);
    assign w_arrive   = i_if_valid & w_if_ready;
    assign w_push     = w_arrive & ~i_ex_flush;
    assign w_pop      = w_id_valid & i_dec_ready & ~i_ex_flush;

    // Everything held plus the stale packet arriving with the flush is lost;
    // one extra bit catches the carry so the counter can saturate.
    assign w_drop_sum = {1'b0, r_flush_drops}
                      + (DROP_W+1)'(r_count)
                      + (DROP_W+1)'(w_arrive);

    // Pointer, occupancy and drop-counter update; flush collapses the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_flush_drops <= '0;
        end else if (i_ex_flush) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_flush_drops <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}}
                                                : w_drop_sum[DROP_W-1:0];
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Packet storage, written on accepted pushes only and never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{pc: i_if_pc, instr: i_if_instr};
        end
    end

    // Head falls through combinationally; masked to NOP/0 when empty.
    assign w_head        = r_mem[r_rd_ptr];
    assign o_if_ready    = w_if_ready;
    assign o_id_valid    = w_id_valid;
    assign o_id_instr    = w_id_valid ? w_head.instr : RV_NOP;
    assign o_id_pc       = w_id_valid ? w_head.pc    : 64'h0;
    assign o_occupancy   = r_count;
    assign o_flush_drops = r_flush_drops;

endmodule
`default_nettype wire

// File: tb/tb_id_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_fetch_queue
//  Description : Self-checking bench for id_fetch_queue. A queue-based model
//                tracks what the decoder must see; directed sequences cover
//                reset, fill, drain, streaming, wrap, flush and saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_if_valid = 1'b0;
    logic [31:0]       i_if_instr = '0;
    logic [63:0]       i_if_pc = '0;
    logic              o_if_ready;
    logic              i_ex_flush = 1'b0;
    logic              o_id_valid;
    logic [31:0]       o_id_instr;
    logic [63:0]       o_id_pc;
    logic              i_dec_ready = 1'b0;
    logic [CNT_W-1:0]  o_occupancy;
    logic [DROP_W-1:0] o_flush_drops;

    int checks   = 0;
    int failures = 0;

    id_fetch_queue #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_if_valid    (i_if_valid),
        .i_if_instr    (i_if_instr),
        .i_if_pc       (i_if_pc),
        .o_if_ready    (o_if_ready),
        .i_ex_flush    (i_ex_flush),
        .o_id_valid    (o_id_valid),
        .o_id_instr    (o_id_instr),
        .o_id_pc       (o_id_pc),
        .i_dec_ready   (i_dec_ready),
        .o_occupancy   (o_occupancy),
        .o_flush_drops (o_flush_drops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_pc[$];
    logic [31:0] m_instr[$];
    int          m_drops = 0;
    bit          m_live  = 0;

    // Apply the queue rules to the inputs seen at each rising edge.
    always @(posedge clk) begin
        bit acc;
        m_live = 1;
        if (rst) begin
            m_pc.delete();
            m_instr.delete();
            m_drops = 0;
        end else begin
            acc = i_if_valid && (m_pc.size() < DEPTH);
            if (i_ex_flush) begin
                m_drops = m_drops + m_pc.size() + (acc ? 1 : 0);
                if (m_drops > DROP_MAX) m_drops = DROP_MAX;
                m_pc.delete();
                m_instr.delete();
            end else begin
                if (m_pc.size() > 0 && i_dec_ready) begin
                    void'(m_pc.pop_front());
                    void'(m_instr.pop_front());
                end
                if (acc) begin
                    m_pc.push_back(i_if_pc);
                    m_instr.push_back(i_if_instr);
                end
            end
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("model_valid", 64'(o_id_valid), 64'(m_pc.size() != 0));
            chk("model_instr", 64'(o_id_instr), 64'((m_pc.size() != 0) ? m_instr[0] : NOP));
            chk("model_pc", o_id_pc, (m_pc.size() != 0) ? m_pc[0] : 64'h0);
            chk("model_ready", 64'(o_if_ready), 64'(m_pc.size() < DEPTH));
            chk("model_occ", 64'(o_occupancy), 64'(m_pc.size()));
            chk("model_drops", 64'(o_flush_drops), 64'(m_drops));
        end
    end

    // ---------------- stimulus ----------------
    // Apply one cycle of inputs (called at a falling edge), return at the next.
    task automatic drive(input logic v, input logic [63:0] pc, input logic dr, input logic fl);
        i_if_valid  = v;
        i_if_pc     = pc;
        i_if_instr  = pc[31:0] ^ 32'hA5A5_0000;
        i_dec_ready = dr;
        i_ex_flush  = fl;
        @(negedge clk);
    endtask

    logic [9:0] wrap_v  = 10'b1101110111;
    logic [9:0] wrap_dr = 10'b0110111011;

    initial begin
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0);
        chk("reset_valid", 64'(o_id_valid), 64'd0);
        chk("reset_instr", 64'(o_id_instr), 64'h13);
        chk("reset_pc", o_id_pc, 64'h0);
        chk("reset_ready", 64'(o_if_ready), 64'd1);
        chk("reset_occ", 64'(o_occupancy), 64'd0);
        chk("reset_drops", 64'(o_flush_drops), 64'd0);

        // Fill to full with the decoder stalled; a 5th packet must bounce.
        drive(1, 64'h100, 0, 0);
        chk("latency_pc", o_id_pc, 64'h100);
        chk("latency_instr", 64'(o_id_instr), 64'(32'h0000_0100 ^ 32'hA5A5_0000));
        drive(1, 64'h104, 0, 0);
        drive(1, 64'h108, 0, 0);
        drive(1, 64'h10C, 0, 0);
        chk("fill_occ", 64'(o_occupancy), 64'd4);
        chk("fill_ready", 64'(o_if_ready), 64'd0);
        drive(1, 64'h110, 0, 0);
        chk("full_occ", 64'(o_occupancy), 64'd4);
        chk("full_head", o_id_pc, 64'h100);

        // Drain in order; a pop while full must not let 0x110 in yet.
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc", o_id_pc, 64'h100 + 64'(4 * k));
            drive(0, 0, 1, 0);
        end
        chk("drain_empty", 64'(o_id_valid), 64'd0);
        drive(0, 0, 1, 0);
        chk("empty_pop_occ", 64'(o_occupancy), 64'd0);

        // Streaming at occupancy 1.
        drive(1, 64'h300, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            drive(1, 64'h300 + 64'(4 * k), 1, 0);
            chk("stream_occ", 64'(o_occupancy), 64'd1);
            chk("stream_pc", o_id_pc, 64'h300 + 64'(4 * k));
        end
        drive(0, 0, 1, 0);
        chk("stream_drops", 64'(o_flush_drops), 64'd0);

        // Push/pop mixes across pointer wrap; the model checks ordering.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 10; k++) begin
                drive(wrap_v[k], 64'h500 + 64'(16 * r + 4 * k), wrap_dr[k], 0);
            end
        end
        for (int k = 0; k < 6; k++) drive(0, 0, 1, 0);
        chk("wrap_empty", 64'(o_occupancy), 64'd0);

        // Flush with 3 held plus one arriving packet.
        drive(1, 64'h400, 0, 0);
        drive(1, 64'h404, 0, 0);
        drive(1, 64'h408, 0, 0);
        drive(1, 64'h40C, 0, 1);
        chk("flush_occ", 64'(o_occupancy), 64'd0);
        chk("flush_valid", 64'(o_id_valid), 64'd0);
        chk("flush_instr", 64'(o_id_instr), 64'h13);
        chk("flush_drops", 64'(o_flush_drops), 64'd4);
        drive(1, 64'h200, 0, 0);
        chk("post_flush_pc", o_id_pc, 64'h200);
        drive(0, 0, 1, 0);

        // Flush while empty and idle changes nothing.
        drive(0, 0, 0, 1);
        chk("idle_flush_drops", 64'(o_flush_drops), 64'd4);
        chk("idle_flush_occ", 64'(o_occupancy), 64'd0);

        // Drive the drop counter past all-ones.
        for (int k = 0; k < DROP_MAX; k++) drive(1, 64'h600, 0, 1);
        chk("sat_drops", 64'(o_flush_drops), 64'hFFFF);
        drive(1, 64'h600, 0, 1);
        chk("sat_hold", 64'(o_flush_drops), 64'hFFFF);
        drive(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
